// File: rtl/trit_pkg.sv
// Shared trit definitions: code points and the signed digit value of a code.
// The resolution stage and the word packer both use this package.
package trit_pkg;

    typedef logic [1:0] trit_code_t;

    localparam trit_code_t TRIT_POS      = 2'b00;
    localparam trit_code_t TRIT_NEG      = 2'b01;
    localparam trit_code_t TRIT_UNSTABLE = 2'b10;
    localparam trit_code_t TRIT_ILLEGAL  = 2'b11;

    // Collect-side state of the packer.
    typedef enum logic {
        COLLECT = 1'b0,
        PEND    = 1'b1
    } pk_state_e;

    // Balanced digit value of a code; unstable and illegal codes contribute nothing.
    function automatic logic signed [1:0] trit_val(input trit_code_t code);
        case (code)
            TRIT_POS: trit_val = 2'sd1;
            TRIT_NEG: trit_val = -2'sd1;
            default:  trit_val = 2'sd0;
        endcase
    endfunction

endpackage

// File: rtl/trit_out_reg.sv
// One-entry valid/ready holding register for a packed word and its metadata.
// Handshake: the word is presented while valid_o is high and is consumed on a
// cycle where valid_o & ready_i. Contents stay stable until consumed. A load
// in the same cycle as a pop replaces the word and keeps valid_o high.
module trit_out_reg #(
    parameter int WORD_W = 12,
    parameter int VAL_W  = 11,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic [VAL_W-1:0]  value_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic              err_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [WORD_W-1:0] word_o,
    output logic [VAL_W-1:0]  value_o,
    output logic [CNT_W-1:0]  len_o,
    output logic              err_o
);

    localparam logic [WORD_W-1:0] EMPTY_WORD = {(WORD_W/2){2'b10}};

    logic              valid_q;
    logic [WORD_W-1:0] word_q;
    logic [VAL_W-1:0]  value_q;
    logic [CNT_W-1:0]  len_q;
    logic              err_q;

    // Capture a new word on load; otherwise drop valid once the word is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            word_q  <= EMPTY_WORD;
            value_q <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            word_q  <= word_i;
            value_q <= value_i;
            len_q   <= len_i;
            err_q   <= err_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign word_o  = word_q;
    assign value_o = value_q;
    assign len_o   = len_q;
    assign err_o   = err_q;

endmodule

// File: rtl/trit_word_packer.sv
// Packs resolved trits LSB-first into NTRITS-wide words and computes each word's
// balanced value. The collect register and the output register form a two-deep
// buffer so collection of the next word overlaps the drain of the current one.
// Handshakes: a trit is taken when in_valid & in_ready; a word is taken when
// out_valid & out_ready. in_ready is a pure function of registered state.
module trit_word_packer
    import trit_pkg::*;
#(
    parameter int NTRITS = 6,
    parameter int VAL_W  = 11,
    parameter int CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [1:0]            in_trit,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*NTRITS-1:0]   out_word,
    output logic [VAL_W-1:0]      out_value,
    output logic [CNT_W-1:0]      out_len,
    output logic                  out_err,
    output logic                  dbg_state_o
);

    localparam int                WORD_W     = 2 * NTRITS;
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(NTRITS);
    localparam logic [WORD_W-1:0] EMPTY_WORD = {NTRITS{TRIT_UNSTABLE}};

    pk_state_e                state_q, state_d;
    logic [WORD_W-1:0]        slots_q, slots_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic signed [VAL_W-1:0]  weight_q, weight_d;
    logic signed [VAL_W-1:0]  acc_q, acc_d;
    logic                     err_q, err_d;

    // Collect state as it would be after this cycle's trit (if any) is added.
    logic [WORD_W-1:0]        slots_a;
    logic [CNT_W-1:0]         count_a;
    logic signed [VAL_W-1:0]  weight_a;
    logic signed [VAL_W-1:0]  acc_a;
    logic                     err_a;
    logic signed [1:0]        tv;

    logic accept;
    logic close;
    logic pop;
    logic out_free;
    logic load;

    logic [WORD_W-1:0] load_word;
    logic [VAL_W-1:0]  load_value;
    logic [CNT_W-1:0]  load_len;
    logic              load_err;

    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_free = !out_valid || out_ready;
    assign tv       = trit_val(in_trit);

    // Fold the incoming trit into the running word, value, weight and error flag.
    always_comb begin
        slots_a  = slots_q;
        count_a  = count_q;
        weight_a = weight_q;
        acc_a    = acc_q;
        err_a    = err_q;
        if (accept) begin
            for (int i = 0; i < NTRITS; i++) begin
                if (count_q == CNT_W'(i)) begin
                    slots_a[2*i +: 2] = in_trit;
                end
            end
            count_a  = count_q + CNT_W'(1);
            weight_a = (weight_q <<< 1) + weight_q;
            if (tv == 2'sd1) begin
                acc_a = acc_q + weight_q;
            end else if (tv == -2'sd1) begin
                acc_a = acc_q - weight_q;
            end else begin
                err_a = 1'b1;
            end
        end
    end

    // A word closes when it fills, or on flush with at least one trit collected.
    assign close = (state_q == COLLECT) &&
                   ((count_a == FULL_CNT) || (flush && (count_a != '0)));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: park a closed word when the output is busy, release on pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (close && !out_free) state_d = PEND;
            PEND:    if (pop)                state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // FSM outputs: trits are refused only while a finished word waits.
    always_comb begin
        in_ready    = (state_q == COLLECT);
        dbg_state_o = state_q;
    end

    // Collect register update and transfer into the output register.
    always_comb begin
        slots_d  = slots_q;
        count_d  = count_q;
        weight_d = weight_q;
        acc_d    = acc_q;
        err_d    = err_q;
        load     = 1'b0;
        case (state_q)
            COLLECT: begin
                if (close && out_free) begin
                    load     = 1'b1;
                    slots_d  = EMPTY_WORD;
                    count_d  = '0;
                    weight_d = VAL_W'(1);
                    acc_d    = '0;
                    err_d    = 1'b0;
                end else begin
                    slots_d  = slots_a;
                    count_d  = count_a;
                    weight_d = weight_a;
                    acc_d    = acc_a;
                    err_d    = err_a;
                end
            end
            PEND: begin
                if (pop) begin
                    load     = 1'b1;
                    slots_d  = EMPTY_WORD;
                    count_d  = '0;
                    weight_d = VAL_W'(1);
                    acc_d    = '0;
                    err_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // A pending word is already complete in the collect registers.
    assign load_word  = (state_q == PEND) ? slots_q : slots_a;
    assign load_value = (state_q == PEND) ? acc_q   : acc_a;
    assign load_len   = (state_q == PEND) ? count_q : count_a;
    assign load_err   = (state_q == PEND) ? err_q   : err_a;

    // Collect register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots_q  <= EMPTY_WORD;
            count_q  <= '0;
            weight_q <= VAL_W'(1);
            acc_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            slots_q  <= slots_d;
            count_q  <= count_d;
            weight_q <= weight_d;
            acc_q    <= acc_d;
            err_q    <= err_d;
        end
    end

    trit_out_reg #(
        .WORD_W (WORD_W),
        .VAL_W  (VAL_W),
        .CNT_W  (CNT_W)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .word_i  (load_word),
        .value_i (load_value),
        .len_i   (load_len),
        .err_i   (load_err),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .word_o  (out_word),
        .value_o (out_value),
        .len_o   (out_len),
        .err_o   (out_err)
    );

endmodule
